// File: rtl/mp_alu_seq_pkg.sv
// Shared types for the multi-precision sequencer: the byte ALU opcode set,
// the wide-operation command encoding and the sequencer state encoding.
package definitions;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_INC = 3'd2,
      OP_DEC = 3'd3,
      OP_ADC = 3'd4
   } op_code;

   typedef enum logic [1:0] {
      CMD_ADD = 2'b00,
      CMD_SUB = 2'b01,
      CMD_INC = 2'b10,
      CMD_DEC = 2'b11
   } mp_cmd_t;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LO   = 3'd1,
      S_HI_A = 3'd2,
      S_HI_C = 3'd3,
      S_DONE = 3'd4
   } mp_state_t;

   // Byte-0 ALU opcode for each wide command.
   function automatic op_code cmd_to_op(input mp_cmd_t cmd);
      case (cmd)
         CMD_ADD: cmd_to_op = OP_ADD;
         CMD_SUB: cmd_to_op = OP_SUB;
         CMD_INC: cmd_to_op = OP_INC;
         default: cmd_to_op = OP_DEC;
      endcase
   endfunction

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU. ov_o is carry for additions and borrow for
// subtractions; z_o flags a zero rt_i operand.
module alu
   import definitions::*;
(
   input  op_code     op_i,
   input  logic [7:0] rs_i,
   input  logic [7:0] rt_i,
   input  logic       ov_i,
   output logic [7:0] result_o,
   output logic       ov_o,
   output logic       z_o
);

   logic [8:0] s;

   always_comb begin
      s = '0;
      case (op_i)
         OP_ADD:  s = {1'b0, rt_i} + {1'b0, rs_i};
         OP_SUB:  s = {1'b0, rt_i} - {1'b0, rs_i};
         OP_INC:  s = {1'b0, rt_i} + 9'd1;
         OP_DEC:  s = {1'b0, rt_i} - 9'd1;
         OP_ADC:  s = {1'b0, rt_i} + {1'b0, rs_i} + {8'd0, ov_i};
         default: s = '0;
      endcase
   end

   assign result_o = s[7:0];
   assign ov_o     = s[8];
   assign z_o      = (rt_i == 8'd0);

endmodule

// File: rtl/mp_alu_seq.sv
// NBYTES-wide ADD/SUB/INC/DEC sequenced LSB-first through one 8-bit ALU,
// with the carry/borrow chained between bytes in cy_q.
module mp_alu_seq
   import definitions::*;
#(
   parameter int NBYTES = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  mp_cmd_t               cmd_i,
   input  logic [8*NBYTES-1:0]   a_i,
   input  logic [8*NBYTES-1:0]   b_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [8*NBYTES-1:0]   result_o,
   output logic                  carry_o,
   output logic                  zero_o,
   output mp_state_t             dbg_state_o
);

   localparam int W  = 8 * NBYTES;
   localparam int IW = $clog2(NBYTES);
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

   mp_state_t     state_q, state_d;
   mp_cmd_t       cmd_q, cmd_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d, r_q, r_d;
   logic [W-1:0]  result_q, result_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [7:0]    t_q, t_d;
   logic          cy_q, cy_d, c1_q, c1_d;
   logic          carry_q, carry_d, zero_q, zero_d;

   op_code        alu_op;
   logic [7:0]    alu_rs, alu_rt, alu_res;
   logic          alu_ov_in, alu_ov;
   logic [IW+2:0] bofs;
   logic          start_ok, is_ab, is_up;

   assign bofs     = {idx_q, 3'b000};
   assign start_ok = start_i && (state_q == S_IDLE || state_q == S_DONE);
   assign is_ab    = (cmd_q == CMD_ADD) || (cmd_q == CMD_SUB);
   assign is_up    = (cmd_q == CMD_ADD) || (cmd_q == CMD_INC);

   alu u_alu (
      .op_i     (alu_op),
      .rs_i     (alu_rs),
      .rt_i     (alu_rt),
      .ov_i     (alu_ov_in),
      .result_o (alu_res),
      .ov_o     (alu_ov),
      .z_o      ()
   );

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      a_d       = a_q;
      b_d       = b_q;
      r_d       = r_q;
      idx_d     = idx_q;
      t_d       = t_q;
      cy_d      = cy_q;
      c1_d      = c1_q;
      result_d  = result_q;
      carry_d   = carry_q;
      zero_d    = zero_q;
      alu_op    = OP_ADC;
      alu_rs    = 8'd0;
      alu_rt    = 8'd0;
      alu_ov_in = 1'b0;

      case (state_q)
         S_LO: begin
            alu_op          = cmd_to_op(cmd_q);
            alu_rt          = a_q[bofs +: 8];
            alu_rs          = b_q[bofs +: 8];
            r_d[bofs +: 8]  = alu_res;
            cy_d            = alu_ov;
            idx_d           = idx_q + 1'b1;
            state_d         = is_ab ? S_HI_A : S_HI_C;
         end
         S_HI_A: begin
            alu_op  = (cmd_q == CMD_ADD) ? OP_ADD : OP_SUB;
            alu_rt  = a_q[bofs +: 8];
            alu_rs  = b_q[bofs +: 8];
            t_d     = alu_res;
            c1_d    = alu_ov;
            state_d = S_HI_C;
         end
         S_HI_C: begin
            // Fix-up always runs; with no pending borrow ADC+0 passes the byte through.
            alu_rt = is_ab ? t_q : a_q[bofs +: 8];
            if (is_up) begin
               alu_op    = OP_ADC;
               alu_ov_in = cy_q;
            end else begin
               alu_op    = cy_q ? OP_DEC : OP_ADC;
            end
            r_d[bofs +: 8] = alu_res;
            cy_d           = is_ab ? (c1_q | alu_ov) : alu_ov;
            if (idx_q == LAST) begin
               state_d  = S_DONE;
               result_d = r_d;
               carry_d  = cy_d;
               zero_d   = ~|r_d;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = is_ab ? S_HI_A : S_HI_C;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = state_q;
      endcase

      if (start_ok) begin
         cmd_d   = cmd_i;
         a_d     = a_i;
         b_d     = b_i;
         idx_d   = '0;
         cy_d    = 1'b0;
         state_d = S_LO;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         cmd_q    <= CMD_ADD;
         a_q      <= '0;
         b_q      <= '0;
         r_q      <= '0;
         idx_q    <= '0;
         t_q      <= '0;
         cy_q     <= 1'b0;
         c1_q     <= 1'b0;
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         a_q      <= a_d;
         b_q      <= b_d;
         r_q      <= r_d;
         idx_q    <= idx_d;
         t_q      <= t_d;
         cy_q     <= cy_d;
         c1_q     <= c1_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
      end
   end

   assign busy_o      = (state_q == S_LO) || (state_q == S_HI_A) || (state_q == S_HI_C);
   assign done_o      = (state_q == S_DONE);
   assign result_o    = result_q;
   assign carry_o     = carry_q;
   assign zero_o      = zero_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mp_alu_seq.sv
// Bench for mp_alu_seq: directed corner cases plus randomized operations
// checked cycle by cycle against a whole-word arithmetic reference.
module tb_mp_alu_seq;
   import definitions::*;

   localparam int NBYTES = 2;
   localparam int W      = 8 * NBYTES;

   logic          clk = 1'b0;
   logic          rst_i, start_i;
   mp_cmd_t       cmd_i;
   logic [W-1:0]  a_i, b_i;
   logic          busy_o, done_o, carry_o, zero_o;
   logic [W-1:0]  result_o;
   mp_state_t     dbg_state;

   int            err_cnt = 0;
   int            chk_cnt = 0;
   logic [W:0]    exp_q[$];
   logic [W-1:0]  last_res;

   mp_alu_seq #(.NBYTES(NBYTES)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .cmd_i       (cmd_i),
      .a_i         (a_i),
      .b_i         (b_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .result_o    (result_o),
      .carry_o     (carry_o),
      .zero_o      (zero_o),
      .dbg_state_o (dbg_state)
   );

   // ---- clock / reset ----
   always #5 clk = ~clk;

   // ---- checking ----
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Whole-word reference: {carry_or_borrow, result} modulo 2^W.
   function automatic logic [W:0] model(input mp_cmd_t c, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] ones;
      ones = '1;
      case (c)
         CMD_ADD: model = {1'b0, a} + {1'b0, b};
         CMD_SUB: model = {(a < b), W'(a - b)};
         CMD_INC: model = {(a == ones), W'(a + 1)};
         default: model = {(a == '0), W'(a - 1)};
      endcase
   endfunction

   function automatic int alu_cycles(input mp_cmd_t c);
      alu_cycles = (c == CMD_ADD || c == CMD_SUB) ? 2 * NBYTES - 1 : NBYTES;
   endfunction

   // ---- driver ----
   // Called at a falling edge; that cycle is cycle 0. poke>0 pulses a stray
   // start in that cycle. chain=1 returns in the done cycle so the caller
   // can start the next operation back to back.
   task automatic run_op(input mp_cmd_t c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int poke, input bit chain);
      int           k;
      logic [W:0]   e;
      logic [W-1:0] held;
      k    = alu_cycles(c);
      held = last_res;
      exp_q.push_back(model(c, a, b));
      start_i = 1'b1;
      cmd_i   = c;
      a_i     = a;
      b_i     = b;
      for (int cyc = 1; cyc <= k + 1; cyc++) begin
         @(negedge clk);
         check("busy", 32'(busy_o), 32'(cyc <= k));
         check("done", 32'(done_o), 32'(cyc == k + 1));
         if (cyc <= k) begin
            check("held", 32'(result_o), 32'(held));
         end else begin
            e = exp_q.pop_front();
            check("result", 32'(result_o), 32'(e[W-1:0]));
            check("carry", 32'(carry_o), 32'(e[W]));
            check("zero", 32'(zero_o), 32'(e[W-1:0] == '0));
            last_res = e[W-1:0];
         end
         start_i = (cyc == poke);
         if (cyc == poke) begin
            cmd_i = mp_cmd_t'($urandom_range(0, 3));
            a_i   = W'($urandom);
            b_i   = W'($urandom);
         end
      end
      if (!chain) begin
         @(negedge clk);
         check("done_end", 32'(done_o), 32'd0);
         check("busy_end", 32'(busy_o), 32'd0);
      end
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       pick_operand = '0;
         1:       pick_operand = '1;
         2:       pick_operand = W'(8'hFF);
         3:       pick_operand = W'(1);
         default: pick_operand = W'($urandom);
      endcase
   endfunction

   // ---- stimulus ----
   initial begin
      bit saw_done;
      rst_i    = 1'b1;
      start_i  = 1'b0;
      cmd_i    = CMD_ADD;
      a_i      = '0;
      b_i      = '0;
      last_res = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_result", 32'(result_o), 32'd0);
      check("rst_carry", 32'(carry_o), 32'd0);
      check("rst_zero", 32'(zero_o), 32'd0);
      rst_i = 1'b0;
      @(negedge clk);
      check("idle_busy", 32'(busy_o), 32'd0);

      run_op(CMD_ADD, 16'h00FF, 16'h0001, 0, 1'b0);
      run_op(CMD_ADD, 16'hFFFF, 16'h0001, 0, 1'b0);
      run_op(CMD_SUB, 16'h0100, 16'h0001, 0, 1'b0);
      run_op(CMD_SUB, 16'h0000, 16'h0001, 0, 1'b0);
      run_op(CMD_INC, 16'h00FF, 16'h5A5A, 0, 1'b0);
      run_op(CMD_DEC, 16'h0000, 16'hFFFF, 0, 1'b0);
      run_op(CMD_ADD, 16'h1234, 16'h0F0F, 2, 1'b0);
      run_op(CMD_DEC, 16'h1234, 16'h0000, 0, 1'b1);
      run_op(CMD_ADD, 16'h1111, 16'h2222, 0, 1'b0);

      // Reset in cycle 2 of a SUB aborts it without a done pulse.
      start_i = 1'b1;
      cmd_i   = CMD_SUB;
      a_i     = 16'h0100;
      b_i     = 16'h0001;
      @(negedge clk);
      start_i = 1'b0;
      check("abort_busy1", 32'(busy_o), 32'd1);
      @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_done", 32'(done_o), 32'd0);
      check("abort_result", 32'(result_o), 32'd0);
      check("abort_carry", 32'(carry_o), 32'd0);
      check("abort_zero", 32'(zero_o), 32'd0);
      last_res = '0;
      saw_done = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (done_o !== 1'b0) saw_done = 1'b1;
      end
      check("abort_no_done", 32'(saw_done), 32'd0);

      for (int n = 0; n < 150; n++) begin
         run_op(mp_cmd_t'($urandom_range(0, 3)), pick_operand(), pick_operand(),
                ($urandom_range(0, 3) == 0) ? 2 : 0,
                (n != 149) && ($urandom_range(0, 3) == 0));
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      err_cnt++;
      $display("FAIL timeout: simulation did not complete");
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/mp_alu_seq.md
# mp_alu_seq

Multi-precision arithmetic sequencer that performs NBYTES-wide ADD, SUB, INC and DEC by driving the 8-bit `alu` one byte per cycle. Carries and borrows are chained between bytes. It sits beside the core datapath and serves wide counters and address arithmetic. Operands are latched on a start pulse, the FSM walks the bytes LSB-first, and the block pulses `done_o` with a registered result, carry and zero flag.

## Interface
- `NBYTES`, default 2: operand width in bytes (≥2); word width W = 8·NBYTES.
- `clk_i` in 1: the only clock; all state updates on its rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: request pulse; sampled only when the block is idle or done.
- `cmd_i` in 2: `mp_cmd_t` (00 ADD, 01 SUB, 10 INC, 11 DEC).
- `a_i` in W: operand A; the minuend for SUB and the only operand for INC/DEC.
- `b_i` in W: operand B; ignored for INC/DEC.
- `busy_o` out 1: an operation is in flight.
- `done_o` out 1: one-cycle pulse; results are valid.
- `result_o` out W: result, held until the next accepted start.
- `carry_o` out 1: final carry (ADD/INC) or borrow (SUB/DEC).
- `zero_o` out 1: `result_o` == 0.

## Operation
- The FSM (`mp_state_t`) has five states: IDLE, LO, HI_A, HI_C, DONE. A byte index `idx` runs from 0 to NBYTES-1, and a 1-bit chain register `cy` holds the carry or borrow.
- **Start:** accepted in IDLE or DONE when `start_i`=1. The block latches A, B and cmd, clears `idx` and `cy`, and moves to LO.
- **LO** (byte 0):
  - ALU op is ADD, SUB, INC or DEC per cmd, with `rt_i`=A[0], `rs_i`=B[0].
  - R[0] takes `result_o`; `cy` takes `ov_o`.
  - Next state is HI_A for ADD/SUB, HI_C for INC/DEC; `idx` increments.
- **HI_A** (ADD/SUB only): ALU ADD or SUB on A[idx], B[idx]. The partial byte goes to temp `t` and the partial carry to `c1`. Next state is HI_C.
- **HI_C:** the carry fix-up, with operand `rt_i` equal to `t` (ADD/SUB) or A[idx] (INC/DEC).
  - ADD/INC: op is ADC with `ov_i`=`cy`.
  - SUB/DEC: op is DEC if `cy`=1, else ADC with `ov_i`=0 (pass-through).
  - R[idx] takes `result_o`.
  - `cy` takes `c1 | ov_o` for ADD/SUB, or `ov_o` for INC/DEC. Both partial carries can never be 1 together.
  - If `idx`=NBYTES-1, go to DONE; else increment `idx` and go to HI_A (ADD/SUB) or HI_C (INC/DEC).
- **DONE:**
  - `done_o` is high for this one cycle.
  - `result_o`, `carry_o` (= `cy`) and `zero_o` (= ~|R, computed over the full word) are registered outputs.
  - The ALU's own `z_o` is not used; it reflects `rt_i`, not the result.
  - Next state is IDLE, or LO if a new start is accepted in this cycle.
- Overflow wraps modulo 2^W, with carry/borrow reported on `carry_o`.
- `start_i` while busy is ignored: no latch, no queue.
- `cmd_i`, `a_i` and `b_i` are don't-care except in the start cycle.

## Timing
- Reset values: state IDLE; `busy_o`, `done_o`, `carry_o` and `zero_o` are 0; `result_o` is 0.
- Latency from the start cycle (cycle 0):
  - ALU cycles K = 2·NBYTES-1 for ADD/SUB and K = NBYTES for INC/DEC.
  - The ALU ops run in cycles 1..K.
  - `busy_o` is high in cycles 1..K.
  - `done_o` and the valid outputs appear in cycle K+1.
- Latency is fixed: HI_C is never skipped, even when `cy`=0.
- A start accepted during DONE gives back-to-back operation: `busy_o` goes high in the next cycle and the old result stays held until the new DONE.
- Reset asserted in any state returns to IDLE on the next edge and clears all outputs. The aborted operation produces no `done_o`.
- The ALU is purely combinational; every ALU output is captured on the edge that ends its state.

## Structure
- `definitions` package:
  - gains `mp_cmd_t` (2-bit enum ADD/SUB/INC/DEC) and `mp_state_t`.
  - reuses the existing `op_code` enum to drive the ALU opcode.
- One sub-module: the existing `alu`, instantiated once, with its `op_i`, `rs_i`, `rt_i` and `ov_i` driven combinationally from the state, `idx` and `cy`.
- Byte selection uses indexed part-selects on the latched A, B and R.

## Test plan
- ADD, NBYTES=2: 0x00FF+0x0001 gives 0x0100, carry 0, zero 0. `busy_o` is high in cycles 1–3 and `done_o` in cycle 4.
- ADD 0xFFFF+0x0001 gives 0x0000, carry 1, zero 1. SUB 0x0100-0x0001 gives 0x00FF, borrow 0. SUB 0x0000-0x0001 gives 0xFFFF, borrow 1.
- INC 0x00FF gives 0x0100 with `done_o` in cycle 3. DEC 0x0000 gives 0xFFFF, borrow 1. DEC 0x1234 gives 0x1233, borrow 0.
- A `start_i` pulse in cycle 2 of an ADD is ignored: the result is that of the first operation and only one `done_o` pulse occurs.
- `rst_i` in cycle 2 of a SUB: `busy_o` is 0 next cycle, all outputs are 0, and `done_o` never pulses.
- Start in the DONE cycle with ADD 0x1111+0x2222: the previous result is held through cycle 3 of the new operation, then 0x3333 is reported with carry 0.
